// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: operand widths, the "value present" tag
// and the station-tag base assigned to each functional unit.
package tomasulo_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    localparam logic [TAG_W-1:0] TAG_READY = '0;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_MEM = 2'd2
    } fu_e;

    // Each FU owns a contiguous block of 4 station tags; tag 0 stays reserved.
    function automatic int station_tag_base(input fu_e fu);
        case (fu)
            FU_ALU:  station_tag_base = 1;
            FU_MUL:  station_tag_base = 5;
            FU_MEM:  station_tag_base = 9;
            default: station_tag_base = 1;
        endcase
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix for a reservation station: older_reg[j][i]=1 means entry j is
// older than entry i. Produces a one-hot grant for the oldest ready entry.
module rs_age_select #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc_sel,
    input  logic [DEPTH-1:0] busy,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant
);

    logic [DEPTH-1:0] older_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row
            // A new entry's row is cleared (older than nobody) and its column
            // takes the current busy vector (younger than every busy entry).
            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    older_reg[gi] <= '0;
                end else if (flush) begin
                    older_reg[gi] <= '0;
                end else if (alloc_sel[gi]) begin
                    older_reg[gi] <= '0;
                end else if (|alloc_sel) begin
                    older_reg[gi] <= (older_reg[gi] & ~alloc_sel) |
                                     (alloc_sel & {DEPTH{busy[gi]}});
                end
            end
        end
    endgenerate

    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_reg[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/reservation_station_n.sv
// DEPTH-entry reservation station: allocates into the lowest free slot,
// captures operands from the CDB, and issues the oldest ready entry.
module reservation_station_n #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int OP_W     = 5,
    parameter int TAG_BASE = 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [OP_W-1:0]   alloc_op,
    input  logic [TAG_W-1:0]  alloc_tag1,
    input  logic [TAG_W-1:0]  alloc_tag2,
    input  logic [DATA_W-1:0] alloc_data1,
    input  logic [DATA_W-1:0] alloc_data2,
    output logic [TAG_W-1:0]  alloc_slot_tag,
    input  logic              bc_valid,
    input  logic [TAG_W-1:0]  bc_tag,
    input  logic [DATA_W-1:0] bc_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [DATA_W-1:0] issue_data1,
    output logic [DATA_W-1:0] issue_data2,
    output logic [TAG_W-1:0]  issue_tag,
    output logic [CNT_W-1:0]  count
);
    import tomasulo_pkg::TAG_READY;

    logic              busy_reg [DEPTH];
    logic [OP_W-1:0]   op_reg   [DEPTH];
    logic [TAG_W-1:0]  q1_reg   [DEPTH];
    logic [TAG_W-1:0]  q2_reg   [DEPTH];
    logic [DATA_W-1:0] v1_reg   [DEPTH];
    logic [DATA_W-1:0] v2_reg   [DEPTH];
    logic [CNT_W-1:0]  count_reg;

    logic [DEPTH-1:0] busy_vec;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] alloc_sel;
    logic             alloc_fire;
    logic             issue_fire;
    logic             bc_live;
    logic             found;

    assign alloc_ready = (count_reg != CNT_W'(DEPTH));
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign issue_valid = |ready_vec;
    assign issue_fire  = issue_valid & issue_ready;
    assign bc_live     = bc_valid && (bc_tag != TAG_READY);
    assign count       = count_reg;

    always_comb begin
        alloc_sel      = '0;
        found          = 1'b0;
        alloc_slot_tag = TAG_W'(TAG_BASE);
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy_reg[i] && !found) begin
                found          = 1'b1;
                alloc_sel[i]   = alloc_fire;
                alloc_slot_tag = TAG_W'(TAG_BASE + i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign busy_vec[gi]  = busy_reg[gi];
            assign ready_vec[gi] = busy_reg[gi] && (q1_reg[gi] == TAG_READY) &&
                                   (q2_reg[gi] == TAG_READY);

            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    busy_reg[gi] <= 1'b0;
                    op_reg[gi]   <= '0;
                    q1_reg[gi]   <= '0;
                    q2_reg[gi]   <= '0;
                    v1_reg[gi]   <= '0;
                    v2_reg[gi]   <= '0;
                end else if (flush) begin
                    busy_reg[gi] <= 1'b0;
                end else if (alloc_sel[gi]) begin
                    busy_reg[gi] <= 1'b1;
                    op_reg[gi]   <= alloc_op;
                    // Operand may be broadcast in the very cycle it is dispatched.
                    if (bc_live && bc_tag == alloc_tag1) begin
                        q1_reg[gi] <= TAG_READY;
                        v1_reg[gi] <= bc_data;
                    end else begin
                        q1_reg[gi] <= alloc_tag1;
                        v1_reg[gi] <= alloc_data1;
                    end
                    if (bc_live && bc_tag == alloc_tag2) begin
                        q2_reg[gi] <= TAG_READY;
                        v2_reg[gi] <= bc_data;
                    end else begin
                        q2_reg[gi] <= alloc_tag2;
                        v2_reg[gi] <= alloc_data2;
                    end
                end else begin
                    if (issue_fire && grant[gi]) begin
                        busy_reg[gi] <= 1'b0;
                    end
                    if (busy_reg[gi] && bc_live && q1_reg[gi] == bc_tag) begin
                        q1_reg[gi] <= TAG_READY;
                        v1_reg[gi] <= bc_data;
                    end
                    if (busy_reg[gi] && bc_live && q2_reg[gi] == bc_tag) begin
                        q2_reg[gi] <= TAG_READY;
                        v2_reg[gi] <= bc_data;
                    end
                end
            end
        end
    endgenerate

    rs_age_select #(.DEPTH(DEPTH)) u_age (
        .clk       (clk),
        .nRST      (nRST),
        .flush     (flush),
        .alloc_sel (alloc_sel),
        .busy      (busy_vec),
        .ready     (ready_vec),
        .grant     (grant)
    );

    always_comb begin
        issue_op    = '0;
        issue_data1 = '0;
        issue_data2 = '0;
        issue_tag   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_op    = op_reg[i];
                issue_data1 = v1_reg[i];
                issue_data2 = v2_reg[i];
                issue_tag   = TAG_W'(TAG_BASE + i);
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else if (alloc_fire && !issue_fire) begin
            count_reg <= count_reg + 1'b1;
        end else if (issue_fire && !alloc_fire) begin
            count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: tb/tb_reservation_station_n.sv
// Scenario bench for reservation_station_n: expected issue records are
// queued as stimulus is driven and popped as the station issues.
module tb_reservation_station_n;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [4:0]  alloc_op = '0;
    logic [3:0]  alloc_tag1 = '0, alloc_tag2 = '0;
    logic [31:0] alloc_data1 = '0, alloc_data2 = '0;
    logic [3:0]  alloc_slot_tag;
    logic        bc_valid = 1'b0;
    logic [3:0]  bc_tag = '0;
    logic [31:0] bc_data = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [4:0]  issue_op;
    logic [31:0] issue_data1, issue_data2;
    logic [3:0]  issue_tag;
    logic [2:0]  count;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  tag;
    } rec_t;

    rec_t sb[$];
    rec_t got, exp_rec;
    logic to;
    logic [3:0] slot;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reservation_station_n dut (
        .clk(clk), .nRST(nRST), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
        .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
        .alloc_data1(alloc_data1), .alloc_data2(alloc_data2),
        .alloc_slot_tag(alloc_slot_tag),
        .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_data1(issue_data1), .issue_data2(issue_data2), .issue_tag(issue_tag),
        .count(count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle allocation; reports the slot tag shown during the request.
    task automatic alloc(input logic [4:0] op, input logic [3:0] t1, input logic [3:0] t2,
                         input logic [31:0] d1, input logic [31:0] d2, output logic [3:0] s);
        alloc_valid = 1'b1; alloc_op = op; alloc_tag1 = t1; alloc_tag2 = t2;
        alloc_data1 = d1; alloc_data2 = d2;
        s = alloc_slot_tag;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [3:0] t, input logic [31:0] d);
        bc_valid = 1'b1; bc_tag = t; bc_data = d;
        step();
        bc_valid = 1'b0; bc_tag = '0; bc_data = '0;
    endtask

    // Waits (bounded) for a presented entry and accepts it.
    task automatic take_issue(output rec_t r, output logic timeout);
        timeout = 1'b1;
        r = '0;
        for (int i = 0; i < 20; i++) begin
            if (issue_valid) begin
                r = {issue_op, issue_data1, issue_data2, issue_tag};
                timeout = 1'b0;
                issue_ready = 1'b1;
                step();
                issue_ready = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        #3;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%b want=1", alloc_ready); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%b want=0", issue_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if ({issue_op, issue_data1, issue_data2, issue_tag} !== '0) begin bad++; $display("FAIL reset_issue_bus got=%h want=0", {issue_op, issue_data1, issue_data2, issue_tag}); end
        @(negedge clk);
        nRST = 1'b1;
        step();
    endtask

    task automatic test_basic();
        alloc(5'd3, 4'd0, 4'd0, 32'd5, 32'd7, slot);
        total++; if (slot !== 4'd1) begin bad++; $display("FAIL basic_slot got=%0d want=1", slot); end
        sb.push_back({5'd3, 32'd5, 32'd7, 4'd1});
        total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL basic_issue_valid got=%b want=1", issue_valid); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", count); end
        take_issue(got, to); exp_rec = sb.pop_front();
        total++; if (to || got !== exp_rec) begin bad++; $display("FAIL basic_issue got=%h to=%b want=%h", got, to, exp_rec); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL basic_count_after got=%0d want=0", count); end
    endtask

    task automatic test_alloc_capture();
        bc_valid = 1'b1; bc_tag = 4'd6; bc_data = 32'hAA;
        alloc(5'd4, 4'd6, 4'd0, 32'h11, 32'h22, slot);
        bc_valid = 1'b0; bc_tag = '0; bc_data = '0;
        sb.push_back({5'd4, 32'hAA, 32'h22, 4'd1});
        total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL capture_ready got=%b want=1", issue_valid); end
        take_issue(got, to); exp_rec = sb.pop_front();
        total++; if (to || got !== exp_rec) begin bad++; $display("FAIL capture_issue got=%h to=%b want=%h", got, to, exp_rec); end
    endtask

    task automatic test_wakeup_order();
        alloc(5'd5, 4'd6, 4'd0, 32'h1, 32'h2, slot);
        alloc(5'd6, 4'd0, 4'd0, 32'h3, 32'h4, slot);
        sb.push_back({5'd6, 32'h3, 32'h4, 4'd2});
        take_issue(got, to); exp_rec = sb.pop_front();
        total++; if (to || got !== exp_rec) begin bad++; $display("FAIL order_b_first got=%h to=%b want=%h", got, to, exp_rec); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL order_a_waiting got=%b want=0", issue_valid); end
        bc_valid = 1'b1; bc_tag = 4'd6; bc_data = 32'h66;
        #1;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL order_same_cycle_wake got=%b want=0", issue_valid); end
        step();
        bc_valid = 1'b0; bc_tag = '0; bc_data = '0;
        sb.push_back({5'd5, 32'h66, 32'h2, 4'd1});
        take_issue(got, to); exp_rec = sb.pop_front();
        total++; if (to || got !== exp_rec) begin bad++; $display("FAIL order_a_after got=%h to=%b want=%h", got, to, exp_rec); end
        // Older entry Q sits at a higher index than the younger R.
        alloc(5'd7, 4'd0, 4'd0, 32'h10, 32'h11, slot);
        alloc(5'd8, 4'd8, 4'd0, 32'h0, 32'h21, slot);
        sb.push_back({5'd7, 32'h10, 32'h11, 4'd1});
        take_issue(got, to); exp_rec = sb.pop_front();
        total++; if (to || got !== exp_rec) begin bad++; $display("FAIL age_p got=%h to=%b want=%h", got, to, exp_rec); end
        alloc(5'd9, 4'd8, 4'd0, 32'h0, 32'h31, slot);
        total++; if (slot !== 4'd1) begin bad++; $display("FAIL age_reuse_slot got=%0d want=1", slot); end
        broadcast(4'd8, 32'h88);
        sb.push_back({5'd8, 32'h88, 32'h21, 4'd2});
        sb.push_back({5'd9, 32'h88, 32'h31, 4'd1});
        for (int k = 0; k < 2; k++) begin
            take_issue(got, to); exp_rec = sb.pop_front();
            total++; if (to || got !== exp_rec) begin bad++; $display("FAIL age_oldest_%0d got=%h to=%b want=%h", k, got, to, exp_rec); end
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            alloc(5'(10 + k), 4'd9, 4'd0, 32'h0, 32'(k), slot);
            total++; if (slot !== 4'(k + 1)) begin bad++; $display("FAIL full_slot_%0d got=%0d want=%0d", k, slot, k + 1); end
        end
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_alloc_ready got=%b want=0", alloc_ready); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", count); end
        alloc(5'd31, 4'd0, 4'd0, 32'hF, 32'hF, slot);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_ignored got=%0d want=4", count); end
        broadcast(4'd9, 32'h99);
        for (int k = 0; k < 4; k++) sb.push_back({5'(10 + k), 32'h99, 32'(k), 4'(k + 1)});
        take_issue(got, to); exp_rec = sb.pop_front();
        total++; if (to || got !== exp_rec) begin bad++; $display("FAIL full_first got=%h to=%b want=%h", got, to, exp_rec); end
        total++; if (alloc_ready !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL full_free got=%b/%0d want=1/3", alloc_ready, count); end
        for (int k = 0; k < 3; k++) begin
            take_issue(got, to); exp_rec = sb.pop_front();
            total++; if (to || got !== exp_rec) begin bad++; $display("FAIL full_drain_%0d got=%h to=%b want=%h", k, got, to, exp_rec); end
        end
    endtask

    task automatic test_stall();
        alloc(5'd2, 4'd0, 4'd0, 32'hDEAD, 32'hBEEF, slot);
        sb.push_back({5'd2, 32'hDEAD, 32'hBEEF, 4'd1});
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({issue_valid, issue_op, issue_data1, issue_data2, issue_tag} !== {1'b1, sb[0]} || count !== 3'd1) begin
                bad++; $display("FAIL stall_hold_%0d got=%h cnt=%0d want=%h cnt=1", k, {issue_op, issue_data1, issue_data2, issue_tag}, count, sb[0]);
            end
            step();
        end
        take_issue(got, to); exp_rec = sb.pop_front();
        total++; if (to || got !== exp_rec || count !== 3'd0) begin bad++; $display("FAIL stall_release got=%h cnt=%0d want=%h cnt=0", got, count, exp_rec); end
    endtask

    task automatic test_back_to_back();
        alloc(5'd1, 4'd0, 4'd0, 32'h1, 32'h1, slot);
        sb.push_back({5'd1, 32'h1, 32'h1, 4'd1});
        sb.push_back({5'd2, 32'h2, 32'h2, 4'd2});
        issue_ready = 1'b1;
        exp_rec = sb.pop_front();
        got = {issue_op, issue_data1, issue_data2, issue_tag};
        alloc(5'd2, 4'd0, 4'd0, 32'h2, 32'h2, slot);
        issue_ready = 1'b0;
        total++; if (got !== exp_rec || slot !== 4'd2) begin bad++; $display("FAIL b2b_issue got=%h slot=%0d want=%h slot=2", got, slot, exp_rec); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_count got=%0d want=1", count); end
        take_issue(got, to); exp_rec = sb.pop_front();
        total++; if (to || got !== exp_rec) begin bad++; $display("FAIL b2b_second got=%h to=%b want=%h", got, to, exp_rec); end
    endtask

    task automatic test_flush_reset();
        alloc(5'd1, 4'd0, 4'd0, 32'h1, 32'h1, slot);
        alloc(5'd2, 4'd0, 4'd0, 32'h2, 32'h2, slot);
        flush = 1'b1; issue_ready = 1'b1;
        alloc(5'd3, 4'd0, 4'd0, 32'h3, 32'h3, slot);
        flush = 1'b0; issue_ready = 1'b0;
        total++; if (count !== 3'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL flush_clear cnt=%0d iv=%b ar=%b want 0/0/1", count, issue_valid, alloc_ready); end
        alloc(5'd4, 4'd0, 4'd0, 32'h4, 32'h4, slot);
        total++; if (issue_valid !== 1'b1 || issue_tag !== 4'd1) begin bad++; $display("FAIL flush_realloc iv=%b tag=%0d want 1/1", issue_valid, issue_tag); end
        #2 nRST = 1'b0;
        #1;
        total++; if (issue_valid !== 1'b0 || count !== 3'd0 || issue_tag !== 4'd0 || issue_data1 !== 32'd0) begin bad++; $display("FAIL async_reset iv=%b cnt=%0d tag=%0d d1=%h want 0", issue_valid, count, issue_tag, issue_data1); end
        @(negedge clk);
        nRST = 1'b1;
        step();
        total++; if (issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL after_reset iv=%b ar=%b want 0/1", issue_valid, alloc_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alloc_capture();
        test_wakeup_order();
        test_full();
        test_stall();
        test_back_to_back();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
